// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: baud divider, frame sequencer and serial shifter.
// Frames are start, 5-8 data bits LSB first, optional parity, then 1/1.5/2 stop bits.
module uart_tx_ctrl (
  input  logic       pclk,
  input  logic       preset,
  input  logic [7:0] dll,
  input  logic [7:0] dlh,
  input  logic [1:0] wls,
  input  logic       stb,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  input  logic       bc,
  input  logic       utrst,
  input  logic       tx_fifo_empty,
  input  logic [7:0] tx_data,
  output logic       tx_fifo_rd_en,
  output logic       tsr_load,
  output logic       shift_cnt_eq,
  output logic       tx_busy,
  output logic       txd
);

  // state   | meaning
  // IDLE    | line marking, waiting for a word
  // START   | start bit (line low)
  // DATA    | wls+5 data bits, LSB first
  // PARITY  | optional parity bit
  // STOP    | stop period, 16/24/32 ticks
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t      state_q, state_d;
  logic [15:0] div;
  logic [15:0] baud_q, baud_d;
  logic [4:0]  tcnt_q, tcnt_d;
  logic [2:0]  bitc_q, bitc_d;
  logic [7:0]  shreg_q, shreg_d;
  logic [1:0]  wls_q, wls_d;
  logic        stb_q, stb_d;
  logic        pen_q, pen_d;
  logic        par_q, par_d;
  logic        txd_q, txd_d;
  logic        tsr_load_q;
  logic        tick, end_bit, pop_ok, load, par_raw;
  logic [7:0]  mask;
  logic [4:0]  stop_last;

  assign div      = {dlh, dll};
  assign tick     = (state_q != S_IDLE) && (div != 16'd0) && (baud_q == 16'd0);
  assign end_bit  = tick && (tcnt_q == 5'd0);
  assign pop_ok   = utrst && !tx_fifo_empty && (div != 16'd0);
  // A new word is taken from IDLE or, for back-to-back frames, in the final stop cycle.
  assign load     = !preset && pop_ok &&
                    ((state_q == S_IDLE) || ((state_q == S_STOP) && end_bit));
  assign par_raw  = ^(tx_data & mask);
  assign stop_last = !stb_q ? 5'd15 : ((wls_q == 2'b00) ? 5'd23 : 5'd31);

  always_comb begin
    mask = 8'hFF;
    case (wls)
      2'b00:   mask = 8'h1F;
      2'b01:   mask = 8'h3F;
      2'b10:   mask = 8'h7F;
      default: mask = 8'hFF;
    endcase
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    tcnt_d  = tcnt_q;
    bitc_d  = bitc_q;
    shreg_d = shreg_q;
    wls_d   = wls_q;
    stb_d   = stb_q;
    pen_d   = pen_q;
    par_d   = par_q;
    txd_d   = 1'b1;

    if ((state_q != S_IDLE) && (div != 16'd0))
      baud_d = (baud_q == 16'd0) ? div - 16'd1 : baud_q - 16'd1;
    if (tick && (tcnt_q != 5'd0))
      tcnt_d = tcnt_q - 5'd1;

    case (state_q)
      S_START: begin
        if (end_bit) begin
          state_d = S_DATA;
          bitc_d  = {1'b0, wls_q} + 3'd4;
          tcnt_d  = 5'd15;
        end
      end
      S_DATA: begin
        if (end_bit) begin
          shreg_d = {1'b0, shreg_q[7:1]};
          tcnt_d  = 5'd15;
          if (bitc_q == 3'd0) begin
            state_d = pen_q ? S_PARITY : S_STOP;
            if (!pen_q) tcnt_d = stop_last;
          end else begin
            bitc_d = bitc_q - 3'd1;
          end
        end
      end
      S_PARITY: begin
        if (end_bit) begin
          state_d = S_STOP;
          tcnt_d  = stop_last;
        end
      end
      S_STOP: begin
        if (end_bit) state_d = S_IDLE;
      end
      default: ;
    endcase

    if ((state_q != S_IDLE) && !utrst) state_d = S_IDLE;

    if (load) begin
      state_d = S_START;
      shreg_d = tx_data;
      wls_d   = wls;
      stb_d   = stb;
      pen_d   = pen;
      par_d   = sp ? ~eps : ~(par_raw ^ eps);
      baud_d  = div - 16'd1;
      tcnt_d  = 5'd15;
    end

    // txd is registered, so it is derived from the state being entered.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shreg_d[0];
      S_PARITY: txd_d = par_q;
      default:  txd_d = 1'b1;
    endcase
    if (bc) txd_d = 1'b0;
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q    <= S_IDLE;
      baud_q     <= 16'd0;
      tcnt_q     <= 5'd0;
      bitc_q     <= 3'd0;
      shreg_q    <= 8'd0;
      wls_q      <= 2'd0;
      stb_q      <= 1'b0;
      pen_q      <= 1'b0;
      par_q      <= 1'b0;
      txd_q      <= 1'b1;
      tsr_load_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      tcnt_q     <= tcnt_d;
      bitc_q     <= bitc_d;
      shreg_q    <= shreg_d;
      wls_q      <= wls_d;
      stb_q      <= stb_d;
      pen_q      <= pen_d;
      par_q      <= par_d;
      txd_q      <= txd_d;
      tsr_load_q <= load;
    end
  end

  assign tx_fifo_rd_en = load;
  assign tsr_load      = tsr_load_q;
  assign shift_cnt_eq  = !preset && utrst && (state_q == S_STOP) && end_bit;
  assign tx_busy       = (state_q != S_IDLE);
  assign txd           = txd_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: frame timing, bit patterns, parity, stop lengths,
// back-to-back frames, abort, break and mid-frame reset.
module tb_uart_tx_ctrl;

  logic       pclk = 1'b0;
  logic       preset;
  logic [7:0] dll, dlh;
  logic [1:0] wls;
  logic       stb, pen, eps, sp, bc, utrst;
  logic       tx_fifo_empty;
  logic [7:0] tx_data;
  logic       tx_fifo_rd_en, tsr_load, shift_cnt_eq, tx_busy, txd;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int pops  = 0;
  int sce_n = 0;
  int viol  = 0;
  int c0, c1, n0;
  logic [7:0] fifo_q[$];

  uart_tx_ctrl dut (
    .pclk(pclk), .preset(preset), .dll(dll), .dlh(dlh), .wls(wls), .stb(stb),
    .pen(pen), .eps(eps), .sp(sp), .bc(bc), .utrst(utrst),
    .tx_fifo_empty(tx_fifo_empty), .tx_data(tx_data),
    .tx_fifo_rd_en(tx_fifo_rd_en), .tsr_load(tsr_load), .shift_cnt_eq(shift_cnt_eq),
    .tx_busy(tx_busy), .txd(txd)
  );

  always #5 pclk = ~pclk;

  task automatic refresh();
    tx_fifo_empty = (fifo_q.size() == 0);
    tx_data       = (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    refresh();
  endtask

  // Cycle counter and event counters, sampled with pre-edge values.
  always @(posedge pclk) begin
    cyc++;
    if (shift_cnt_eq) sce_n++;
    if (tx_fifo_rd_en && tx_fifo_empty) viol++;
    if (tx_fifo_rd_en) begin
      pops++;
      #1;
      if (fifo_q.size() > 0) void'(fifo_q.pop_front());
      refresh();
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for tsr_load (sel=0) or shift_cnt_eq (sel=1) at a negedge.
  task automatic wait_sig(input string tag, input int sel, input int budget);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge pclk);
      if ((sel == 0) ? tsr_load : shift_cnt_eq) begin
        seen = 1'b1;
        break;
      end
    end
    chk(tag, {31'd0, seen}, 32'd1);
  endtask

  task automatic goto(input int target);
    while (cyc < target) @(negedge pclk);
  endtask

  task automatic cfg(input logic [15:0] d, input logic [1:0] w, input logic s,
                     input logic p, input logic e, input logic stick);
    {dlh, dll} = d;
    wls = w; stb = s; pen = p; eps = e; sp = stick;
  endtask

  logic [9:0] exp55;

  initial begin
    preset = 1'b1; bc = 1'b0; utrst = 1'b0;
    cfg(16'd0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    refresh();
    repeat (3) @(negedge pclk);
    chk("rst_txd", {31'd0, txd}, 32'd1);
    chk("rst_busy", {31'd0, tx_busy}, 32'd0);
    chk("rst_rd_en", {31'd0, tx_fifo_rd_en}, 32'd0);
    chk("rst_tsr_load", {31'd0, tsr_load}, 32'd0);
    chk("rst_sce", {31'd0, shift_cnt_eq}, 32'd0);
    preset = 1'b0;
    utrst  = 1'b1;

    // D=0 with a word waiting: nothing may be popped.
    push(8'h33);
    repeat (50) @(negedge pclk);
    chk("d0_pops", pops, 0);
    chk("d0_busy", {31'd0, tx_busy}, 32'd0);
    fifo_q.delete();
    refresh();

    // D=1, 8N1, 0x55: 10 bits of 16 cycles, last stop cycle 159 after tsr_load.
    cfg(16'd1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    exp55 = 10'b1010101010;
    push(8'h55);
    wait_sig("f55_load", 0, 20);
    c0 = cyc;
    chk("f55_busy", {31'd0, tx_busy}, 32'd1);
    for (int i = 0; i < 10; i++) begin
      goto(c0 + 16 * i + 8);
      chk($sformatf("f55_bit%0d", i), {31'd0, txd}, {31'd0, exp55[i]});
    end
    wait_sig("f55_sce", 1, 40);
    chk("f55_sce_cyc", cyc - c0, 159);
    @(negedge pclk);
    chk("f55_idle_busy", {31'd0, tx_busy}, 32'd0);
    chk("f55_idle_txd", {31'd0, txd}, 32'd1);

    // D=3, 8E1, 0x07: parity 1, frame 11 x 48 = 528 cycles.
    cfg(16'd3, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0);
    push(8'h07);
    wait_sig("f07_load", 0, 20);
    c0 = cyc;
    goto(c0 + 3 * 48 + 24);
    chk("f07_d2", {31'd0, txd}, 32'd1);
    goto(c0 + 4 * 48 + 24);
    chk("f07_d3", {31'd0, txd}, 32'd0);
    goto(c0 + 9 * 48 + 24);
    chk("f07_par", {31'd0, txd}, 32'd1);
    wait_sig("f07_sce", 1, 200);
    chk("f07_sce_cyc", cyc - c0, 527);

    // Two queued words at D=1: next start immediately after the stop bit.
    cfg(16'd1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    n0 = pops;
    push(8'hA5);
    push(8'h3C);
    wait_sig("b2b_load1", 0, 20);
    c0 = cyc;
    wait_sig("b2b_sce1", 1, 200);
    c1 = cyc;
    chk("b2b_sce1_cyc", c1 - c0, 159);
    chk("b2b_stop_txd", {31'd0, txd}, 32'd1);
    wait_sig("b2b_load2", 0, 5);
    chk("b2b_gap", cyc - c1, 1);
    chk("b2b_start_txd", {31'd0, txd}, 32'd0);
    wait_sig("b2b_sce2", 1, 200);
    chk("b2b_pops", pops - n0, 2);

    // 5 bits, 1.5 stop: 16 + 80 + 24 = 120 cycles; bit 5 of 0x1F not sent.
    cfg(16'd1, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0);
    push(8'h1F);
    wait_sig("w5_load", 0, 20);
    c0 = cyc;
    goto(c0 + 5 * 16 + 8);
    chk("w5_d4", {31'd0, txd}, 32'd1);
    goto(c0 + 6 * 16 + 8);
    chk("w5_stop", {31'd0, txd}, 32'd1);
    wait_sig("w5_sce", 1, 200);
    chk("w5_sce_cyc", cyc - c0, 119);

    // 6 bits, 2 stop: 16 + 96 + 32 = 144 cycles.
    cfg(16'd1, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0);
    push(8'h00);
    wait_sig("w6_load", 0, 20);
    c0 = cyc;
    wait_sig("w6_sce", 1, 200);
    chk("w6_sce_cyc", cyc - c0, 143);

    // Stick parity with eps=1 gives 0 even though even parity of 0x01 would be 1.
    cfg(16'd1, 2'b11, 1'b0, 1'b1, 1'b1, 1'b1);
    push(8'h01);
    wait_sig("sp_load", 0, 20);
    c0 = cyc;
    goto(c0 + 9 * 16 + 8);
    chk("sp_par", {31'd0, txd}, 32'd0);
    wait_sig("sp_sce", 1, 200);
    chk("sp_sce_cyc", cyc - c0, 175);

    // utrst dropped during data bit 3: line idles next cycle, no stop pulse.
    cfg(16'd1, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    push(8'h00);
    wait_sig("ab_load", 0, 20);
    c0 = cyc;
    goto(c0 + 70);
    chk("ab_pre_txd", {31'd0, txd}, 32'd0);
    n0 = sce_n;
    utrst = 1'b0;
    @(negedge pclk);
    chk("ab_txd", {31'd0, txd}, 32'd1);
    chk("ab_busy", {31'd0, tx_busy}, 32'd0);
    repeat (150) @(negedge pclk);
    chk("ab_no_sce", sce_n - n0, 0);
    utrst = 1'b1;
    repeat (5) @(negedge pclk);
    chk("ab_stay_idle", {31'd0, tx_busy}, 32'd0);

    // Break holds the line low; frame timing unchanged.
    bc = 1'b1;
    repeat (3) @(negedge pclk);
    push(8'hFF);
    wait_sig("bc_load", 0, 20);
    c0 = cyc;
    goto(c0 + 16 + 8);
    chk("bc_d0", {31'd0, txd}, 32'd0);
    goto(c0 + 5 * 16 + 8);
    chk("bc_d4", {31'd0, txd}, 32'd0);
    goto(c0 + 9 * 16 + 8);
    chk("bc_stop", {31'd0, txd}, 32'd0);
    wait_sig("bc_sce", 1, 40);
    chk("bc_sce_cyc", cyc - c0, 159);
    bc = 1'b0;
    repeat (3) @(negedge pclk);

    // Reset mid-frame.
    push(8'h00);
    wait_sig("pr_load", 0, 20);
    c0 = cyc;
    goto(c0 + 50);
    preset = 1'b1;
    @(negedge pclk);
    chk("pr_txd", {31'd0, txd}, 32'd1);
    chk("pr_busy", {31'd0, tx_busy}, 32'd0);
    chk("pr_rd_en", {31'd0, tx_fifo_rd_en}, 32'd0);
    chk("pr_tsr_load", {31'd0, tsr_load}, 32'd0);
    chk("pr_sce", {31'd0, shift_cnt_eq}, 32'd0);
    preset = 1'b0;
    repeat (5) @(negedge pclk);

    chk("pop_while_empty", viol, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
